uart_rx_ctrl: RTL and testbench

Frame-sequencing controller for the UART receiver. It detects a start edge on the oversampled serial line and counts prescale edges and bit positions. It issues one-cycle enables to the data sampler, deserializer, start/parity/stop checkers. It collects their error flags and emits a single `data_valid` pulse per clean frame. It sits between `RX_IN` and the receiver datapath. It is the only source of that datapath's sequencing controls, including the hold/evaluate control of the parity checker.

---
 rtl/uart_rx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detection, edge/bit counting, checker
// strobes and the single registered frame-end verdict.
//
// state  | meaning
// IDLE   | line idle, counters held at 0, waiting for RX_IN low
// START  | start bit; start checker strobed at the sample point
// DATA   | DATA_WIDTH data bits, one deserializer shift per bit
// PARITY | optional parity bit; checker result latched on wrap
// STOP   | stop bit; frame verdict registered on wrap
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_flag_q, par_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  framing_error_q, framing_error_d;

    logic                  edge_last;
    logic                  samp_pt;
    logic [PRESCALE_W-1:0] samp_edge;

    // First cycle the sampler's majority vote is valid.
    assign samp_edge = (PRESCALE >> 1) + PRESCALE_W'(2);
    assign edge_last = (edge_cnt_q == PRESCALE - PRESCALE_W'(1));
    assign samp_pt   = (edge_cnt_q == samp_edge);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q         <= IDLE;
            edge_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            par_en_q        <= 1'b0;
            par_flag_q      <= 1'b0;
            data_valid_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            edge_cnt_q      <= edge_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            par_en_q        <= par_en_d;
            par_flag_q      <= par_flag_d;
            data_valid_q    <= data_valid_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        edge_cnt_d      = edge_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        par_en_d        = par_en_q;
        par_flag_d      = par_flag_q;
        data_valid_d    = 1'b0;
        parity_error_d  = 1'b0;
        framing_error_d = 1'b0;
        strt_chk_en     = 1'b0;
        deser_en        = 1'b0;
        par_chk_en      = 1'b0;
        stp_chk_en      = 1'b0;

        if (state_q != IDLE) begin
            if (edge_last) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                // The detection cycle itself counts as edge 0 of the start bit.
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = PRESCALE_W'(1);
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                strt_chk_en = samp_pt;
                if (edge_last) begin
                    if (strt_glitch) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                deser_en = samp_pt;
                if (edge_last && (bit_cnt_q == LAST_DATA)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk_en = samp_pt;
                if (edge_last) begin
                    par_flag_d = par_en_q & par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                stp_chk_en = samp_pt;
                if (edge_last) begin
                    state_d         = IDLE;
                    bit_cnt_d       = '0;
                    data_valid_d    = !stp_err && !par_flag_q;
                    parity_error_d  = par_flag_q;
                    framing_error_d = stp_err;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    assign dat_samp_en   = (state_q != IDLE);
    assign edge_cnt      = edge_cnt_q;
    assign bit_cnt       = bit_cnt_q;
    assign data_valid    = data_valid_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: a per-cycle line history feeds a frame-level
// reference model; the checker stand-ins respond to the DUT's strobes.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    typedef struct packed {
        logic       rst_n;
        logic       rx;
        logic       pen;
        logic [5:0] psc;
    } stim_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       strt_glitch = 1'b1;
    logic       par_err = 1'b1;
    logic       stp_err = 1'b1;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, parity_error, framing_error;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(6)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PRESCALE      (PRESCALE),
        .PAR_EN        (PAR_EN),
        .strt_glitch   (strt_glitch),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .dat_samp_en   (dat_samp_en),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .deser_en      (deser_en),
        .strt_chk_en   (strt_chk_en),
        .par_chk_en    (par_chk_en),
        .stp_chk_en    (stp_chk_en),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    always #5 CLK = ~CLK;

    stim_t stim_q[$];
    int    n_vec = 0;
    int    n_miscmp = 0;
    int    cyc = 0;

    // reference model state
    bit    line_hist[int];
    bit    busy = 0;
    bit    fe_pend = 0;
    int    t0, m_p, m_pen;
    int    fe_dv, fe_pe, fe_fe;
    int    n_dv_exp = 0, n_dv_obs = 0;
    int    n_err_exp = 0, n_err_obs = 0;

    // checker stand-ins: next values, applied one cycle after the strobe
    logic       sg_nx = 1'b1, pe_nx = 1'b1, se_nx = 1'b1;
    logic [7:0] sh = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== 32'(exp)) begin
            n_miscmp++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_idle(input int n, input logic [5:0] p);
        for (int i = 0; i < n; i++) stim_q.push_back('{1'b1, 1'b1, 1'b0, p});
    endtask

    task automatic push_rst(input int n, input logic rx, input logic [5:0] p);
        for (int i = 0; i < n; i++) stim_q.push_back('{1'b0, rx, 1'b0, p});
    endtask

    task automatic push_frame(input logic [5:0] p, input logic pen, input logic [7:0] d,
                              input bit par_ok, input logic stop_bit, input bit jit, input int cut);
        logic bitv [0:15];
        int   nb, total, n;
        logic pen_c;
        nb = DW + 2 + int'(pen);
        bitv[0] = 1'b0;
        for (int k = 0; k < DW; k++) bitv[k+1] = d[k];
        if (pen) bitv[DW+1] = (^d) ^ !par_ok;
        bitv[nb-1] = stop_bit;
        total = nb * int'(p);
        n = (cut < 0) ? total : cut;
        for (int i = 0; i < n; i++) begin
            pen_c = (i == 0 || !jit) ? pen : logic'($urandom_range(0, 1));
            stim_q.push_back('{1'b1, bitv[i / int'(p)], pen_c, p});
        end
    endtask

    task automatic push_glitch(input logic [5:0] p, input int low);
        for (int i = 0; i < int'(p); i++) stim_q.push_back('{1'b1, (i >= low), 1'b0, p});
    endtask

    task automatic build();
        int         pi, kind;
        logic [5:0] p;
        push_rst(3, 1'b1, 6'd8);
        push_idle(2, 6'd8);
        push_frame(6'd8, 1'b0, 8'hA5, 1, 1'b1, 0, -1);
        push_idle(3, 6'd16);
        push_frame(6'd16, 1'b1, 8'h3C, 1, 1'b1, 0, -1);
        push_idle(2, 6'd16);
        push_frame(6'd16, 1'b1, 8'h3C, 0, 1'b1, 0, -1);
        push_idle(2, 6'd8);
        push_frame(6'd8, 1'b0, 8'h96, 1, 1'b0, 0, -1);
        push_idle(1, 6'd8);
        push_frame(6'd8, 1'b0, 8'h55, 1, 1'b1, 0, -1);
        push_idle(2, 6'd8);
        push_glitch(6'd8, 3);
        push_idle(2, 6'd8);
        push_frame(6'd8, 1'b0, 8'hFF, 1, 1'b1, 0, 4 * 8 + 3);
        push_rst(3, 1'b0, 6'd8);
        push_frame(6'd8, 1'b0, 8'hFF, 1, 1'b1, 0, -1);
        push_idle(2, 6'd8);
        for (int f = 0; f < 16; f++) begin
            pi = $urandom_range(0, 2);
            p = (pi == 0) ? 6'd8 : (pi == 1) ? 6'd16 : 6'd32;
            kind = $urandom_range(0, 7);
            if (kind == 0)
                push_glitch(p, $urandom_range(1, int'(p) / 2 + 1));
            else
                push_frame(p, logic'($urandom_range(0, 1)), 8'($urandom),
                           ($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) != 0), 1, -1);
            push_idle($urandom_range(1, 4), p);
        end
        push_idle(3, 6'd8);
    endtask

    task automatic model_and_check();
        int   x_dse, x_edge, x_bit, x_de, x_sc, x_pc, x_tc, x_dv, x_pe, x_fe;
        int   o, b, e, s, nb;
        logic [7:0] d;
        bit   perr, serr;
        x_dse = 0; x_edge = 0; x_bit = 0; x_de = 0; x_sc = 0; x_pc = 0; x_tc = 0;
        x_dv = 0; x_pe = 0; x_fe = 0;
        line_hist[cyc] = RX_IN;
        if (!RST) begin
            busy = 0;
            fe_pend = 0;
        end else begin
            if (fe_pend) begin
                x_dv = fe_dv; x_pe = fe_pe; x_fe = fe_fe;
                fe_pend = 0;
            end
            if (!busy && !RX_IN) begin
                busy = 1; t0 = cyc; m_p = int'(PRESCALE); m_pen = int'(PAR_EN);
            end
            if (busy) begin
                o = cyc - t0; b = o / m_p; e = o % m_p; s = m_p / 2 + 2;
                nb = DW + 2 + m_pen;
                if (o != 0) begin
                    x_dse = 1; x_edge = e; x_bit = b;
                end
                if (e == s) begin
                    x_sc = (b == 0);
                    x_de = (b >= 1 && b <= DW);
                    x_pc = (m_pen == 1 && b == DW + 1);
                    x_tc = (b == nb - 1);
                end
                if (b == 0 && e == m_p - 1 && line_hist[t0 + s]) begin
                    busy = 0;
                end else if (o == nb * m_p - 1) begin
                    for (int k = 0; k < DW; k++) d[k] = line_hist[t0 + (k + 1) * m_p + s];
                    perr = (m_pen == 1) && (line_hist[t0 + (DW + 1) * m_p + s] != (^d));
                    serr = !line_hist[t0 + (nb - 1) * m_p + s];
                    fe_dv = int'(!serr && !perr); fe_pe = int'(perr); fe_fe = int'(serr);
                    fe_pend = 1;
                    busy = 0;
                end
            end
        end
        n_dv_exp += x_dv;
        n_err_exp += x_pe + x_fe;
        n_dv_obs += int'(data_valid);
        n_err_obs += int'(parity_error) + int'(framing_error);
        check_eq("dat_samp_en", 32'(dat_samp_en), x_dse);
        check_eq("edge_cnt", 32'(edge_cnt), x_edge);
        check_eq("bit_cnt", 32'(bit_cnt), x_bit);
        check_eq("deser_en", 32'(deser_en), x_de);
        check_eq("strt_chk_en", 32'(strt_chk_en), x_sc);
        check_eq("par_chk_en", 32'(par_chk_en), x_pc);
        check_eq("stp_chk_en", 32'(stp_chk_en), x_tc);
        check_eq("data_valid", 32'(data_valid), x_dv);
        check_eq("parity_error", 32'(parity_error), x_pe);
        check_eq("framing_error", 32'(framing_error), x_fe);
    endtask

    task automatic emulate_checkers();
        if (strt_chk_en) begin
            sg_nx = RX_IN;
            sh = '0;
        end
        if (deser_en) sh = {RX_IN, sh[7:1]};
        if (par_chk_en) pe_nx = RX_IN ^ (^sh);
        if (stp_chk_en) se_nx = !RX_IN;
    endtask

    initial begin
        stim_t st;
        build();
        #2 RST = 1'b0;
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            @(posedge CLK);
            #1;
            strt_glitch = sg_nx;
            par_err     = pe_nx;
            stp_err     = se_nx;
            RST         = st.rst_n;
            RX_IN       = st.rx;
            PAR_EN      = st.pen;
            PRESCALE    = st.psc;
            @(negedge CLK);
            model_and_check();
            emulate_checkers();
            cyc++;
        end
        check_eq("dv_pulse_total", 32'(n_dv_obs), n_dv_exp);
        check_eq("err_pulse_total", 32'(n_err_obs), n_err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
